// File: rtl/aes_masked_pkg.sv
// Shared types and helpers for the masked AES S-box datapath: 3-share byte
// struct, prd width and the inverse basis-conversion map.
package aes_masked_pkg;

  localparam int unsigned PRD_W = 16;

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] mask0;
    logic [7:0] mask1;
  } share3_t;

  // Inverse of the forward linear basis map; y is the field-basis byte.
  function automatic logic [7:0] aes_inv_lin_map_byte(input logic [7:0] y);
    logic [7:0] x;
    x[0] = y[2];
    x[1] = y[5] ^ y[1];
    x[2] = y[7] ^ y[5] ^ y[4] ^ y[1];
    x[3] = y[6] ^ y[5] ^ y[4] ^ y[3] ^ y[2] ^ y[1];
    x[4] = y[6] ^ y[1];
    x[5] = y[7] ^ y[6] ^ y[5] ^ y[3] ^ y[2] ^ y[0];
    x[6] = y[7] ^ y[6] ^ y[5] ^ y[3] ^ y[1] ^ y[0];
    x[7] = y[4] ^ y[1];
    return x;
  endfunction

endpackage

// File: rtl/aes_inv_lin_map_comb.sv
// Combinational inverse basis map applied to each share independently.
module aes_inv_lin_map_comb
  import aes_masked_pkg::*;
(
  input  share3_t in_i,
  output share3_t out_o
);

  always_comb begin
    out_o       = '0;
    out_o.data  = aes_inv_lin_map_byte(in_i.data);
    out_o.mask0 = aes_inv_lin_map_byte(in_i.mask0);
    out_o.mask1 = aes_inv_lin_map_byte(in_i.mask1);
  end

endmodule

// File: rtl/aes_inv_lin_map_pipe.sv
// Two-stage 3-share inverse basis-conversion pipeline with valid/ready on both
// sides. Optional share refresh is enabled by defining AES_INV_LIN_MAP_REFRESH_EN.
module aes_inv_lin_map_pipe
  import aes_masked_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [7:0]       data_i,
  input  logic [7:0]       mask0_i,
  input  logic [7:0]       mask1_i,
  input  logic [PRD_W-1:0] prd_i,
  input  logic             prd_valid_i,
  output logic             prd_ack_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [7:0]       data_o,
  output logic [7:0]       mask0_o,
  output logic [7:0]       mask1_o,
  output logic             busy_o
);

  share3_t s1_q, s1_d, s2_q, map_w;
  logic    v1_q, v1_d, v2_q, v2_d;
  logic    adv2, accept, prd_ok;

`ifdef AES_INV_LIN_MAP_REFRESH_EN
  assign prd_ok    = prd_valid_i;
  assign prd_ack_o = accept;

  // Both fresh bytes are folded into data so the unmasked value is unchanged.
  always_comb begin
    s1_d       = '0;
    s1_d.mask0 = mask0_i ^ prd_i[7:0];
    s1_d.mask1 = mask1_i ^ prd_i[15:8];
    s1_d.data  = data_i ^ prd_i[7:0] ^ prd_i[15:8];
  end
`else
  logic unused_prd;
  assign unused_prd = ^{prd_i, prd_valid_i};
  assign prd_ok     = 1'b1;
  assign prd_ack_o  = 1'b0;

  always_comb begin
    s1_d       = '0;
    s1_d.data  = data_i;
    s1_d.mask0 = mask0_i;
    s1_d.mask1 = mask1_i;
  end
`endif

  assign adv2       = v1_q & (~v2_q | out_ready_i);
  assign in_ready_o = ~v1_q | adv2;
  // Gated with rst_ni so the refresh ack stays low while reset is held.
  assign accept     = rst_ni & in_valid_i & in_ready_o & prd_ok;

  always_comb begin
    v2_d = v2_q;
    if (adv2) begin
      v2_d = 1'b1;
    end else if (v2_q && out_ready_i) begin
      v2_d = 1'b0;
    end
    v1_d = v1_q;
    if (accept) begin
      v1_d = 1'b1;
    end else if (adv2) begin
      v1_d = 1'b0;
    end
  end

  aes_inv_lin_map_comb u_map (
    .in_i  (s1_q),
    .out_o (map_w)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      if (accept) begin
        s1_q <= s1_d;
      end
      if (adv2) begin
        s2_q <= map_w;
      end
    end
  end

  assign out_valid_o = v2_q;
  assign busy_o      = v1_q | v2_q;
  assign data_o      = s2_q.data;
  assign mask0_o     = s2_q.mask0;
  assign mask1_o     = s2_q.mask1;

endmodule

// File: tb/tb_aes_inv_lin_map_pipe.sv
// Self-checking bench for aes_inv_lin_map_pipe: directed map/handshake cases
// plus randomized traffic against a matrix-row reference model and queue.
module tb_aes_inv_lin_map_pipe;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [7:0]  data_i, mask0_i, mask1_i;
  logic [15:0] prd_i;
  logic        prd_valid_i;
  logic        prd_ack_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [7:0]  data_o, mask0_o, mask1_o;
  logic        busy_o;

  always #5 clk_i = ~clk_i;

  aes_inv_lin_map_pipe dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .data_i      (data_i),
    .mask0_i     (mask0_i),
    .mask1_i     (mask1_i),
    .prd_i       (prd_i),
    .prd_valid_i (prd_valid_i),
    .prd_ack_o   (prd_ack_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .data_o      (data_o),
    .mask0_o     (mask0_o),
    .mask1_o     (mask1_o),
    .busy_o      (busy_o)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Output bit i is the parity of the input bits selected by ROWS[i].
  logic [7:0] ROWS [8] = '{8'h04, 8'h22, 8'hB2, 8'h7E, 8'h42, 8'hED, 8'hEB, 8'h12};

  function automatic logic [7:0] ref_map(input logic [7:0] y);
    logic [7:0] x;
    for (int i = 0; i < 8; i++) x[i] = ^(y & ROWS[i]);
    return x;
  endfunction

  logic [23:0] exp_q[$];
  logic        hold_pending = 1'b0;
  logic [23:0] held;
  logic [23:0] last_out;
  logic        last_acc, last_ir, last_ov;
  int unsigned n_emit = 0;

  // One cycle: drive on the falling edge, observe 1 time unit later.
  task automatic step(input logic iv, input logic [7:0] d, input logic [7:0] m0,
                      input logic [7:0] m1, input logic [15:0] prd, input logic pv,
                      input logic ordy);
    logic       acc;
    logic [7:0] ed, e0, e1;
    @(negedge clk_i);
    in_valid_i = iv; data_i = d; mask0_i = m0; mask1_i = m1;
    prd_i = prd; prd_valid_i = pv; out_ready_i = ordy;
    #1;
    if (hold_pending) check_eq("hold_stable", {data_o, mask0_o, mask1_o}, held);
`ifdef AES_INV_LIN_MAP_REFRESH_EN
    acc = in_valid_i & in_ready_o & prd_valid_i;
    check_eq("prd_ack", prd_ack_o, acc);
    ed = d ^ prd[7:0] ^ prd[15:8]; e0 = m0 ^ prd[7:0]; e1 = m1 ^ prd[15:8];
`else
    acc = in_valid_i & in_ready_o;
    check_eq("prd_ack", prd_ack_o, 1'b0);
    ed = d; e0 = m0; e1 = m1;
`endif
    check_eq("busy", busy_o, (out_valid_o | (exp_q.size() > (out_valid_o ? 1 : 0))));
    if (out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) check_eq("spurious_out", out_valid_o, 1'b0);
      else check_eq("out_triple", {data_o, mask0_o, mask1_o}, exp_q.pop_front());
      last_out = {data_o, mask0_o, mask1_o};
      n_emit++;
    end
    hold_pending = out_valid_o & ~out_ready_i;
    held = {data_o, mask0_o, mask1_o};
    if (acc) exp_q.push_back({ref_map(ed), ref_map(e0), ref_map(e1)});
    last_acc = acc; last_ir = in_ready_o; last_ov = out_valid_o;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 8'h00, 8'h00, 8'h00, 16'h0000, 1'b0, ordy);
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && exp_q.size() != 0; i++) idle(1'b1);
    idle(1'b1);
    check_eq("drain_empty", exp_q.size(), 0);
  endtask

  logic [7:0] vin [4]  = '{8'h01, 8'h04, 8'hFF, 8'h00};
  logic [7:0] vexp [4] = '{8'h60, 8'h29, 8'h01, 8'h00};

  initial begin
    int unsigned accs, ov_cnt, e0;
    logic [7:0] bp [4];
    rst_ni = 1'b0; in_valid_i = 1'b0; data_i = '0; mask0_i = '0; mask1_i = '0;
    prd_i = '0; prd_valid_i = 1'b0; out_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    check_eq("rst_out_valid", out_valid_o, 1'b0);
    check_eq("rst_busy", busy_o, 1'b0);
    check_eq("rst_in_ready", in_ready_o, 1'b1);
    check_eq("rst_shares", {data_o, mask0_o, mask1_o}, 24'h0);

    // Directed map vectors with 2-cycle latency
    for (int k = 0; k < 4; k++) begin
      step(1'b1, vin[k], 8'h00, 8'h00, 16'h0000, 1'b1, 1'b1);
      check_eq("map_accept", last_acc, 1'b1);
      idle(1'b1);
      check_eq("lat_not_early", last_ov, 1'b0);
      idle(1'b1);
      check_eq("lat_valid", last_ov, 1'b1);
      check_eq("map_const", last_out[23:16], vexp[k]);
    end

    // Masked triple: shares recombine to the map of the secret
    step(1'b1, 8'h5A ^ 8'h3C ^ 8'h81, 8'h3C, 8'h81, 16'h0000, 1'b1, 1'b1);
    idle(1'b1); idle(1'b1);
    check_eq("masked_xor", last_out[23:16] ^ last_out[15:8] ^ last_out[7:0], ref_map(8'h5A));
    check_eq("masked_m0", last_out[15:8], ref_map(8'h3C));

`ifdef AES_INV_LIN_MAP_REFRESH_EN
    step(1'b1, 8'h11, 8'h22, 8'h33, 16'hA55A, 1'b0, 1'b1);
    check_eq("no_prd_accept", last_acc, 1'b0);
    step(1'b1, 8'h11 ^ 8'h22 ^ 8'h33, 8'h22, 8'h33, 16'hA55A, 1'b1, 1'b1);
    idle(1'b1); idle(1'b1);
    check_eq("refresh_m0", last_out[15:8], ref_map(8'h22 ^ 8'h5A));
    check_eq("refresh_m1", last_out[7:0], ref_map(8'h33 ^ 8'hA5));
    check_eq("refresh_xor", last_out[23:16] ^ last_out[15:8] ^ last_out[7:0], ref_map(8'h11));
`endif
    drain();

    // Backpressure: 4 bytes, out_ready low for 5 cycles
    for (int k = 0; k < 4; k++) bp[k] = 8'($urandom);
    accs = 0; e0 = n_emit;
    for (int c = 0; c < 30 && !(accs == 4 && exp_q.size() == 0); c++) begin
      if (accs < 4) step(1'b1, bp[accs], 8'(c), 8'(c * 7), 16'($urandom), 1'b1, c >= 5);
      else idle(1'b1);
      if (last_acc) accs++;
      if (c == 4) begin
        check_eq("bp_accepts", accs, 2);
        check_eq("bp_in_ready_low", last_ir, 1'b0);
      end
    end
    check_eq("bp_emitted", n_emit - e0, 4);
    drain();

    // Full rate: one byte per cycle from the third cycle on
    ov_cnt = 0; e0 = n_emit;
    for (int c = 0; c < 20; c++) begin
      step(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 16'($urandom), 1'b1, 1'b1);
      if (c >= 2 && last_ov) ov_cnt++;
    end
    check_eq("fullrate_valid", ov_cnt, 18);
    check_eq("fullrate_emit", n_emit - e0, 18);
    drain();

    // Reset with both stages full
    step(1'b1, 8'hC3, 8'h11, 8'h22, 16'h1234, 1'b1, 1'b0);
    step(1'b1, 8'h3C, 8'h44, 8'h55, 16'h5678, 1'b1, 1'b0);
    idle(1'b0);
    check_eq("full_in_ready", last_ir, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b0; in_valid_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    check_eq("mid_rst_valid", out_valid_o, 1'b0);
    check_eq("mid_rst_busy", busy_o, 1'b0);
    check_eq("mid_rst_shares", {data_o, mask0_o, mask1_o}, 24'h0);
    check_eq("mid_rst_in_ready", in_ready_o, 1'b1);
    exp_q.delete(); hold_pending = 1'b0;

    // Random traffic
    for (int c = 0; c < 400; c++)
      step(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 16'($urandom),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
